chr_loader: RTL
===============

Name: chr_loader

Overview:
- Upstream feeder of the PPU-to-SDRAM bridge.
- Receives a CHR image as a framed byte stream from the host serial link (UART/AVR rx byte strobe) and writes it sequentially into SDRAM through the shared SDRAM request port.
- When the full image has been written and its checksum verified, raises init_sdram_data, which gates PPU fetches.
- Frame format: sync 0xA5, len_lo, len_hi, len data bytes, 8-bit additive checksum of the data bytes.

Parameters:
- BASE_ADDR, 23'd0, SDRAM byte address of data byte 0.
- MAX_BYTES, 16'd8192, largest accepted len (8 KiB CHR window).
- TIMEOUT_CYCLES, 24'd5_000_000, maximum idle gap between rx bytes inside a frame (100 ms at 50 MHz).
- FIFO_DEPTH, 4, rx byte buffer depth (power of two).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  received byte
- new_rx_data  in  1  one-cycle strobe; rx_data valid
- ram_addr  out  23  SDRAM byte address
- ram_data_in  out  8  SDRAM write data
- ram_rw  out  1  1 = write (always 1 when in_valid)
- in_valid  out  1  one-cycle request strobe
- busy  in  1  SDRAM controller busy
- init_sdram_data  out  1  1 = image loaded and verified
- load_error  out  1  sticky; 1 = last frame failed
- loading  out  1  1 = frame in progress

Behaviour:
- All outputs are registered.
- Reset: state IDLE; FIFO empty; in_valid=0, ram_rw=0, ram_addr=BASE_ADDR, ram_data_in=0; init_sdram_data=0, load_error=0, loading=0; counters cleared.
- Parser FSM:
  - IDLE: byte 0xA5 → LEN_LO; clears load_error and init_sdram_data; sets loading. Any other byte is ignored.
  - LEN_LO: capture len[7:0] → LEN_HI.
  - LEN_HI: capture len[15:8].
    - len > MAX_BYTES → ERROR.
    - len == 0 → CSUM.
    - Otherwise → DATA, with rcnt=0, sum=0.
  - DATA: each byte is pushed to the FIFO, sum += byte (mod 256), rcnt++. When rcnt reaches len → CSUM.
  - CSUM: capture checksum byte → DRAIN.
  - DRAIN: wait until FIFO is empty and no write is outstanding (busy==0), then:
    - checksum == sum → DONE.
    - Otherwise → ERROR.
  - DONE: init_sdram_data=1, loading=0. A byte 0xA5 restarts the load (→ LEN_LO, init_sdram_data drops the next cycle). Other bytes are ignored.
  - ERROR: load_error=1, loading=0, init_sdram_data=0, FIFO flushed. Next cycle → IDLE; load_error stays set until the next sync byte.
- Write engine, independent of the parser:
  - Issues a request when the FIFO is non-empty, busy==0, and no request was issued in the previous cycle (minimum one gap cycle, so that busy is visible).
  - Request: in_valid=1 for exactly one cycle, ram_rw=1, ram_addr=BASE_ADDR+wcnt, ram_data_in=FIFO head. The FIFO pops and wcnt increments in the same cycle.
  - wcnt is cleared on sync.
- FIFO overflow: a push while full → ERROR. The byte is dropped and no write is issued for it.
- Timeout: in LEN_LO, LEN_HI, DATA and CSUM, the idle counter resets on each new_rx_data. Reaching TIMEOUT_CYCLES → ERROR. The counter is inactive in other states.
- Simultaneous push and pop on the FIFO: both take effect, and the occupancy is unchanged.
- rst asserted mid-frame: everything returns to reset values. A write already accepted by the SDRAM completes, but no new request is issued.
- ram_addr arithmetic is 23-bit and wraps modulo 2^23. The integration must guarantee BASE_ADDR + MAX_BYTES ≤ 2^23.

Decomposition:
- Shared package (sdram_pkg / nes_defs):
  - SDRAM address width 23.
  - CHR_BYTES = 8192.
  - SYNC_BYTE = 8'hA5.
  - Parser state encoding (IDLE, LEN_LO, LEN_HI, DATA, CSUM, DRAIN, DONE, ERROR).
- One natural sub-module: byte_fifo (parameterised WIDTH/DEPTH, synchronous flush, full/empty flags), reused for other host-link paths.

Test Plan:
- Frame A5 04 00 11 22 33 44 AA, busy held 0 → writes to addresses 0..3 with data 11, 22, 33, 44; each in_valid lasts 1 cycle with ≥1 gap cycle between requests; init_sdram_data=1 after the last write; load_error=0.
- Same frame with checksum 0xAB → 4 writes issued, then load_error=1 and init_sdram_data=0.
- Frame A5 00 21 → len 0x2100 > 8192 → immediate ERROR, no in_valid pulses.
- Back-to-back rx bytes every 2 cycles with busy high for 20 cycles after each accept → FIFO fills, overflow → load_error=1; the same stimulus with busy high for 3 cycles completes with no error.
- Stop rx after the 2nd data byte, with TIMEOUT_CYCLES=100 → load_error=1 at cycle 100 of the gap; a fresh valid frame afterwards gives init_sdram_data=1.
- While in DONE, send A5 → init_sdram_data=0 the next cycle; a full 8192-byte frame with the correct checksum → 8192 writes at addresses BASE..BASE+8191, then init_sdram_data=1.

Source files
------------

// File: rtl/chr_loader_pkg.sv
// Shared definitions for the CHR image loader: SDRAM geometry, framing constants,
// parser state encoding and the SDRAM write payload.
package chr_loader_pkg;

  localparam int unsigned ADDR_W    = 23;
  localparam int unsigned CHR_BYTES = 8192;
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CSUM,
    ST_DRAIN,
    ST_DONE,
    ST_ERROR
  } parse_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } ram_wr_t;

endpackage

// File: rtl/chr_loader_fifo.sv
// Small synchronous FIFO with flush; head is a combinational read of the oldest entry.
module byte_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] head_c,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_n;
  logic             wr_ok;
  logic             rd_ok;

  // A write into a full FIFO is accepted only when a read frees a slot in the same cycle
  assign rd_ok  = rd_en && !empty;
  assign wr_ok  = wr_en && (!full || rd_ok);
  assign head_c = mem[rd_ptr];

  always_comb begin
    count_n = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_n = count + CW'(1);
      2'b01:   count_n = count - CW'(1);
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count_n;
      full  <= (count_n == CW'(DEPTH));
      empty <= (count_n == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/chr_loader.sv
// Parses a framed CHR image from the host byte stream and streams it into SDRAM,
// flagging completion once the checksum matches.
module chr_loader
  import chr_loader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
  parameter logic [15:0]       MAX_BYTES      = 16'(CHR_BYTES),
  parameter logic [23:0]       TIMEOUT_CYCLES = 24'd5_000_000,
  parameter int unsigned       FIFO_DEPTH     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              new_rx_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data_in,
  output logic              ram_rw,
  output logic              in_valid,
  input  logic              busy,
  output logic              init_sdram_data,
  output logic              load_error,
  output logic              loading
);

  parse_state_e      state, state_n;
  logic [15:0]       len, len_n;
  logic [15:0]       rcnt, rcnt_n;
  logic [7:0]        sum, sum_n;
  logic [7:0]        csum, csum_n;
  logic [23:0]       idle, idle_n;
  logic              init_n, err_n, loading_n;
  logic              push_c, sync_c, issue_c, timed_c, timeout_c;
  logic [15:0]       len_hi_c;
  logic [15:0]       rcnt_inc_c;
  logic [7:0]        head_c;
  logic              fifo_full, fifo_empty;
  logic [ADDR_W-1:0] wcnt;
  ram_wr_t           wr_q;

  byte_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (state == ST_ERROR),
    .wr_en   (push_c),
    .wr_data (rx_data),
    .rd_en   (issue_c),
    .head_c  (head_c),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // The gap after each request lets the controller's busy become visible before the next
  assign issue_c    = !fifo_empty && !busy && !in_valid && (state != ST_ERROR);
  assign timed_c    = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                      (state == ST_DATA)   || (state == ST_CSUM);
  assign timeout_c  = timed_c && !new_rx_data && (idle == TIMEOUT_CYCLES - 24'd1);
  assign len_hi_c   = {rx_data, len[7:0]};
  assign rcnt_inc_c = rcnt + 16'd1;

  always_comb begin
    state_n   = state;
    len_n     = len;
    rcnt_n    = rcnt;
    sum_n     = sum;
    csum_n    = csum;
    init_n    = init_sdram_data;
    err_n     = load_error;
    loading_n = loading;
    push_c    = 1'b0;
    sync_c    = 1'b0;
    idle_n    = (!timed_c || new_rx_data) ? 24'd0 : idle + 24'd1;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (new_rx_data && rx_data == SYNC_BYTE) begin
          state_n   = ST_LEN_LO;
          err_n     = 1'b0;
          init_n    = 1'b0;
          loading_n = 1'b1;
          sync_c    = 1'b1;
          rcnt_n    = '0;
          sum_n     = '0;
        end
      end
      ST_LEN_LO: begin
        if (new_rx_data) begin
          len_n   = {8'h00, rx_data};
          state_n = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (new_rx_data) begin
          len_n  = len_hi_c;
          rcnt_n = '0;
          sum_n  = '0;
          if (len_hi_c > MAX_BYTES)   state_n = ST_ERROR;
          else if (len_hi_c == 16'd0) state_n = ST_CSUM;
          else                        state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        if (new_rx_data) begin
          push_c = 1'b1;
          if (fifo_full && !issue_c) begin
            state_n = ST_ERROR;
          end else begin
            sum_n  = sum + rx_data;
            rcnt_n = rcnt_inc_c;
            if (rcnt_inc_c == len) state_n = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (new_rx_data) begin
          csum_n  = rx_data;
          state_n = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty && !busy && !in_valid) begin
          if (csum == sum) begin
            state_n   = ST_DONE;
            init_n    = 1'b1;
            loading_n = 1'b0;
          end else begin
            state_n = ST_ERROR;
          end
        end
      end
      ST_ERROR: state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase

    if (timeout_c) state_n = ST_ERROR;

    if (state_n == ST_ERROR && state != ST_ERROR) begin
      err_n     = 1'b1;
      loading_n = 1'b0;
      init_n    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      len             <= '0;
      rcnt            <= '0;
      sum             <= '0;
      csum            <= '0;
      idle            <= '0;
      init_sdram_data <= 1'b0;
      load_error      <= 1'b0;
      loading         <= 1'b0;
    end else begin
      state           <= state_n;
      len             <= len_n;
      rcnt            <= rcnt_n;
      sum             <= sum_n;
      csum            <= csum_n;
      idle            <= idle_n;
      init_sdram_data <= init_n;
      load_error      <= err_n;
      loading         <= loading_n;
    end
  end

  // Write engine: runs off the FIFO independently of the parser
  always_ff @(posedge clk) begin
    if (rst) begin
      in_valid <= 1'b0;
      ram_rw   <= 1'b0;
      wr_q     <= '{addr: BASE_ADDR, data: 8'h00};
      wcnt     <= '0;
    end else begin
      in_valid <= issue_c;
      ram_rw   <= issue_c;
      if (issue_c) wr_q <= '{addr: BASE_ADDR + wcnt, data: head_c};
      if (sync_c)       wcnt <= '0;
      else if (issue_c) wcnt <= wcnt + ADDR_W'(1);
    end
  end

  assign ram_addr    = wr_q.addr;
  assign ram_data_in = wr_q.data;

endmodule
